adc_mux: RTL and testbench
==========================

ADC_MUX -- requirements
Module: adc_mux

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of adc channels merged (2..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning output FIFO entries (power of 2, >=2).
REQ-003 SHALL define CHW = ceil(log2(NUM_CH)) and CW = log2(FIFO_DEPTH)+1 as derived widths.
REQ-004 SHALL have port: sck  input  1  clock; all logic on posedge sck.
REQ-005 SHALL have port: rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port: start  input  1  begins arbitration; sampled only in IDLE.
REQ-007 SHALL have port: ch_valid  input  NUM_CH  per-channel adc flag_out (data ready).
REQ-008 SHALL have port: ch_data  input  32*NUM_CH  packed adc data, channel i at bits [32i+31:32i].
REQ-009 SHALL have port: ch_ready  output  NUM_CH  per-channel flag_in to adc (acknowledge), registered.
REQ-010 SHALL have port: out_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port: out_ready  input  1  downstream accepts head entry.
REQ-012 SHALL have port: out_data  output  32  head entry sample.
REQ-013 SHALL have port: out_ch  output  CHW  head entry channel index.
REQ-014 SHALL have port: frame_done  output  1  one-cycle pulse when every channel has been captured once.
REQ-015 SHALL have port: fifo_count  output  CW  current FIFO occupancy.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN, ACK; IDLE->SCAN on start=1; SCAN->ACK on capture; ACK->SCAN unconditionally after one cycle; never returns to IDLE except via rst.
REQ-017 SHALL keep a scan pointer ptr (0..NUM_CH-1), wrapping NUM_CH-1 -> 0.
REQ-018 In SCAN, if ch_valid[ptr]=1 and fifo_count<FIFO_DEPTH: SHALL push {ptr, ch_data[ptr]} into FIFO, set ch_ready<=onehot(ptr), advance ptr, go ACK.
REQ-019 In SCAN, if ch_valid[ptr]=0: SHALL advance ptr and stay in SCAN (one channel examined per cycle).
REQ-020 In SCAN, if ch_valid[ptr]=1 and FIFO full: SHALL hold ptr, push nothing, keep ch_ready=0 (adc retains its data).
REQ-021 In ACK: ch_ready SHALL be high exactly this one cycle, then cleared on the ACK->SCAN edge; no capture occurs in ACK.
REQ-022 ch_ready SHALL be at most one-hot at all times and zero in IDLE.
REQ-023 Full check SHALL use registered fifo_count; a pop in the same cycle does not unblock a push.
REQ-024 FIFO SHALL be first-word-fall-through: out_data/out_ch reflect head whenever out_valid=1.
REQ-025 Pop SHALL occur when out_valid and out_ready; pop with empty FIFO SHALL be ignored.
REQ-026 Simultaneous push and pop SHALL leave fifo_count unchanged and preserve order.
REQ-027 SHALL track a NUM_CH-bit captured mask; on capture set bit ptr; when mask becomes all-ones, frame_done pulses next cycle for one cycle and mask clears (capture in that same cycle sets its bit in the fresh mask).
REQ-028 Capture-to-out_valid latency SHALL be 1 cycle when the FIFO was empty.

Reset
REQ-029 On rst=1 SHALL immediately force: state=IDLE, ptr=0, ch_ready=0, out_valid=0, out_data=0, out_ch=0, frame_done=0, fifo_count=0, mask=0; FIFO contents discarded.
REQ-030 Reset asserted mid-ACK SHALL drop ch_ready asynchronously; the pending FIFO entry is lost.
REQ-031 After rst release SHALL wait in IDLE for start=1 again.

Verification
REQ-032 Single channel: start, ch_valid=0001, ch_data[0]=0x12345600, out_ready=1 -> ch_ready=0001 for 1 cycle; out_valid with out_data=0x12345600, out_ch=0.
REQ-033 All valid: ch_valid=1111, data ch i = 0xA0000000+i -> outputs in order ch0,1,2,3; each ch_ready one cycle; frame_done pulses once after ch3 capture.
REQ-034 Backpressure: out_ready=0, 4 channels repeatedly valid, FIFO_DEPTH=8 -> fifo_count reaches 8, ch_ready stays 0, ptr held; out_ready=1 resumes capture without loss or reorder.
REQ-035 Sparse: only ch2 valid -> capture within <=4 SCAN cycles; out_ch=2; frame_done never pulses.
REQ-036 Push+pop: FIFO count 3, out_ready=1 during capture -> fifo_count stays 3, order preserved.
REQ-037 Reset in ACK: rst=1 while ch_ready=0100 -> ch_ready=0, fifo_count=0, state IDLE; no output until next start.

Source files
------------

// File: rtl/adc_mux.sv
// Purpose: round-robin merge of NUM_CH ADC channels into one tagged first-word-fall-through output FIFO.
// Latency: a captured sample is visible at out_valid/out_data one cycle after its capture edge.
// Backpressure: a full FIFO holds the scan pointer and withholds ch_ready, so the ADC keeps its sample.
module adc_mux #(
    parameter  int NUM_CH     = 4,
    parameter  int FIFO_DEPTH = 8,
    localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  sck,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_CH-1:0]     ch_valid,
    input  logic [32*NUM_CH-1:0]  ch_data,
    output logic [NUM_CH-1:0]     ch_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic [CHW-1:0]        out_ch,
    output logic                  frame_done,
    output logic [CW-1:0]         fifo_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [CHW-1:0]    PTR_LAST = CHW'(NUM_CH - 1);
    localparam logic [CW-1:0]     DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [NUM_CH-1:0] ALL_CH   = '1;

    logic [1:0]          state_q, state_d;
    logic [CHW-1:0]      ptr_q, ptr_d;
    logic [NUM_CH-1:0]   ch_ready_q, ch_ready_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic                frame_done_q, frame_done_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CHW+31:0]     mem_q [FIFO_DEPTH];
    logic [CHW+31:0]     mem_d [FIFO_DEPTH];

    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                sel_valid;
    logic [31:0]         sel_data;
    logic [NUM_CH-1:0]   ptr_oh;
    logic [CHW-1:0]      ptr_inc;
    logic [NUM_CH-1:0]   mask_set;

    // Current channel under the scan pointer and the FIFO status seen by the scanner.
    always_comb begin
        sel_valid = ch_valid[ptr_q];
        sel_data  = ch_data[32*ptr_q +: 32];
        ptr_oh    = NUM_CH'(1) << ptr_q;
        ptr_inc   = (ptr_q == PTR_LAST) ? '0 : CHW'(ptr_q + 1'b1);
        // Registered count only: a pop in this cycle cannot make room for a push.
        fifo_full = (count_q == DEPTH_C);
        pop       = (count_q != '0) && out_ready;
    end

    // Scan FSM: examine one channel per cycle, capture, then spend one cycle acknowledging.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ch_ready_d = '0;
        push       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (sel_valid) begin
                    if (!fifo_full) begin
                        push       = 1'b1;
                        ch_ready_d = ptr_oh;
                        ptr_d      = ptr_inc;
                        state_d    = ST_ACK;
                    end
                end else begin
                    ptr_d = ptr_inc;
                end
            end
            ST_ACK: begin
                state_d = ST_SCAN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame tracking: once every channel has been captured, pulse frame_done and start a fresh mask.
    always_comb begin
        mask_set = mask_q | (push ? ptr_oh : '0);
        if (mask_set == ALL_CH) begin
            mask_d       = '0;
            frame_done_d = 1'b1;
        end else begin
            mask_d       = mask_set;
            frame_done_d = 1'b0;
        end
    end

    // FIFO pointers, occupancy and storage update.
    always_comb begin
        wr_ptr_d = push ? AW'(wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop  ? AW'(rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {ptr_q, sel_data};
        end
    end

    // State registers; reset discards all FIFO contents and any pending acknowledge.
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            ch_ready_q   <= '0;
            mask_q       <= '0;
            frame_done_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ch_ready_q   <= ch_ready_d;
            mask_q       <= mask_d;
            frame_done_q <= frame_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_q        <= mem_d;
        end
    end

    // Head entry falls through to the outputs.
    always_comb begin
        ch_ready   = ch_ready_q;
        out_valid  = (count_q != '0);
        out_data   = mem_q[rd_ptr_q][31:0];
        out_ch     = mem_q[rd_ptr_q][CHW+31:32];
        frame_done = frame_done_q;
        fifo_count = count_q;
    end

endmodule

// File: tb/tb_adc_mux.sv
// Directed bench for adc_mux with a behavioural ADC that drops or refills its sample on acknowledge.
module tb_adc_mux;

    logic         sck;
    logic         rst;
    logic         start;
    logic [3:0]   ch_valid;
    logic [127:0] ch_data;
    logic [3:0]   ch_ready;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_ch;
    logic         frame_done;
    logic [3:0]   fifo_count;

    int n_vec;
    int n_err;
    bit refill;
    int rnd [4];

    adc_mux #(.NUM_CH(4), .FIFO_DEPTH(8)) dut (
        .sck        (sck),
        .rst        (rst),
        .start      (start),
        .ch_valid   (ch_valid),
        .ch_data    (ch_data),
        .ch_ready   (ch_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .frame_done (frame_done),
        .fifo_count (fifo_count)
    );

    initial begin
        sck = 1'b0;
        forever #5 sck = ~sck;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock; then the ADC model reacts to any acknowledge it sees.
    task automatic tick();
        @(posedge sck);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (ch_ready[i]) begin
                if (refill) begin
                    rnd[i]++;
                    ch_data[32*i +: 32] = {8'hB0, rnd[i][7:0], 16'(i)};
                end else begin
                    ch_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        ch_valid  = '0;
        ch_data   = '0;
        refill    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_scan();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int  k;
        bit  seen_fd;
        n_vec     = 0;
        n_err     = 0;
        refill    = 1'b0;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        ch_valid  = '0;
        ch_data   = '0;
        for (int i = 0; i < 4; i++) rnd[i] = 0;
        #1;

        // Reset state
        chk("rst_ch_ready",   32'(ch_ready),   32'h0);
        chk("rst_out_valid",  32'(out_valid),  32'h0);
        chk("rst_out_data",   out_data,        32'h0);
        chk("rst_out_ch",     32'(out_ch),     32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_fifo_count", 32'(fifo_count), 32'h0);

        // Single channel
        do_reset();
        out_ready = 1'b1;
        ch_data[31:0] = 32'h12345600;
        ch_valid = 4'b0001;
        tick();
        chk("idle_no_ready", 32'(ch_ready), 32'h0);
        start_scan();
        tick();
        chk("single_ready",  32'(ch_ready),   32'h1);
        chk("single_valid",  32'(out_valid),  32'h1);
        chk("single_data",   out_data,        32'h12345600);
        chk("single_ch",     32'(out_ch),     32'h0);
        chk("single_count",  32'(fifo_count), 32'h1);
        tick();
        chk("single_ready_clr", 32'(ch_ready),  32'h0);
        chk("single_popped",    32'(out_valid), 32'h0);

        // All channels valid, in-order capture and a frame_done pulse after ch3
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) ch_data[32*i +: 32] = 32'hA0000000 + 32'(i);
        ch_valid = 4'hF;
        start_scan();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("all_ready",   32'(ch_ready),   32'(1 << i));
            chk("all_ch",      32'(out_ch),     32'(i));
            chk("all_data",    out_data,        32'hA0000000 + 32'(i));
            chk("all_fd",      32'(frame_done), (i == 3) ? 32'h1 : 32'h0);
            tick();
            chk("all_ready_clr", 32'(ch_ready),   32'h0);
            chk("all_fd_clr",    32'(frame_done), 32'h0);
            chk("all_popped",    32'(out_valid),  32'h0);
        end

        // Backpressure: fill to depth, hold, then drain without loss or reorder
        do_reset();
        refill = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rnd[i] = 0;
            ch_data[32*i +: 32] = {8'hB0, 8'h00, 16'(i)};
        end
        ch_valid = 4'hF;
        start_scan();
        for (int c = 0; c < 20; c++) tick();
        chk("bp_full_count", 32'(fifo_count), 32'h8);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_hold_ready", 32'(ch_ready),   32'h0);
            chk("bp_hold_count", 32'(fifo_count), 32'h8);
        end
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 200 && k < 12; c++) begin
            if (out_valid) begin
                chk("bp_ch",   32'(out_ch), 32'(k % 4));
                chk("bp_data", out_data,    {8'hB0, 8'(k / 4), 16'(k % 4)});
                k++;
            end
            tick();
        end
        chk("bp_drain_n", 32'(k), 32'd12);

        // Sparse: only ch2 valid
        do_reset();
        out_ready = 1'b1;
        ch_data[95:64] = 32'hC0C0C002;
        ch_valid = 4'b0100;
        start_scan();
        tick();
        tick();
        tick();
        chk("sparse_ready", 32'(ch_ready), 32'h4);
        chk("sparse_ch",    32'(out_ch),   32'h2);
        chk("sparse_data",  out_data,      32'hC0C0C002);
        seen_fd = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (frame_done) seen_fd = 1'b1;
            tick();
        end
        chk("sparse_no_fd", 32'(seen_fd), 32'h0);

        // Simultaneous push and pop at occupancy 3
        do_reset();
        for (int i = 0; i < 4; i++) ch_data[32*i +: 32] = 32'hD0000000 + 32'(i);
        ch_valid = 4'hF;
        start_scan();
        for (int c = 0; c < 5; c++) tick();
        chk("pp_count3", 32'(fifo_count), 32'h3);
        tick();
        out_ready = 1'b1;
        tick();
        chk("pp_count_same", 32'(fifo_count), 32'h3);
        chk("pp_ready",      32'(ch_ready),   32'h8);
        k = 1;
        for (int c = 0; c < 50 && k < 4; c++) begin
            if (out_valid) begin
                chk("pp_ch",   32'(out_ch), 32'(k));
                chk("pp_data", out_data,    32'hD0000000 + 32'(k));
                k++;
            end
            tick();
        end
        chk("pp_drain_n", 32'(k), 32'd4);

        // Reset during ACK
        do_reset();
        ch_data[95:64] = 32'hE0000002;
        ch_valid = 4'b0100;
        start_scan();
        tick();
        tick();
        tick();
        chk("ra_ready", 32'(ch_ready),   32'h4);
        chk("ra_count", 32'(fifo_count), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("ra_async_ready", 32'(ch_ready),   32'h0);
        chk("ra_async_count", 32'(fifo_count), 32'h0);
        chk("ra_async_valid", 32'(out_valid),  32'h0);
        chk("ra_async_data",  out_data,        32'h0);
        tick();
        rst = 1'b0;
        ch_valid = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("ra_idle_ready", 32'(ch_ready),  32'h0);
            chk("ra_idle_valid", 32'(out_valid), 32'h0);
        end
        start_scan();
        tick();
        tick();
        tick();
        chk("ra_restart_ready", 32'(ch_ready),   32'h4);
        chk("ra_restart_count", 32'(fifo_count), 32'h1);
        chk("ra_restart_ch",    32'(out_ch),     32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
